// File: rtl/batpu_pkg.sv
// -----------------------------------------------------------------------------
// batpu_pkg
//   Shared types and constants for the memory-port arbiter.
//   - arb_state_t : arbiter sequencer states
//   - SPACE_*     : encoding of bus_space (which requester owns the bus)
//   - *_W         : address/data widths of the instruction and data ports
// -----------------------------------------------------------------------------
package batpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam logic SPACE_INST = 1'b0;
  localparam logic SPACE_DATA = 1'b1;

  localparam int IADDR_W = 10;
  localparam int DADDR_W = 8;
  localparam int IDATA_W = 16;
  localparam int DDATA_W = 8;

  // Watchdog counter width; TIMEOUT is limited to 1..255.
  localparam int WD_W = 8;

endpackage

// File: rtl/mem_watchdog.sv
// -----------------------------------------------------------------------------
// mem_watchdog
//   Enable-gated cycle counter that flags a hung bus transaction.
//   expired_o is high during the TIMEOUT-th enabled cycle after clr_i, so a
//   completion taken on it lands TIMEOUT + 1 enabled cycles after the grant.
// Ports
//   clk        : clock
//   sync_rst   : synchronous active-high reset, clears the count
//   clr_i      : restart counting from zero (asserted on a grant)
//   en_i       : count this cycle (enabled cycle spent in BUSY)
//   expired_o  : count has reached the timeout boundary
// -----------------------------------------------------------------------------
module mem_watchdog
  import batpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic sync_rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [WD_W-1:0] LAST_CNT = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] cnt_q;

  assign expired_o = (cnt_q == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      // Saturate at the boundary so a stalled exit can never wrap the count.
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port external memory bus between the icache refill path
//   (16-bit read-only, 10-bit word address) and the core data path (8-bit
//   read/write, 8-bit address). Round-robin grant, one transaction at a time,
//   one-cycle acknowledge with registered read data, watchdog completion.
// Ports
//   clk, clk_en, sync_rst       : clock, global enable, sync active-high reset
//   i_req/i_addr                : instruction read request (held until i_ack)
//   i_rdata/i_ack/i_err         : instruction completion
//   d_req/d_we/d_addr/d_wdata   : data request (held until d_ack)
//   d_rdata/d_ack/d_err         : data completion
//   bus_req/space/we/addr/wdata : external bus command (registered)
//   bus_rdata/bus_ack           : external bus response
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import batpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               clk_en,
  input  logic               sync_rst,
  input  logic               i_req,
  input  logic [IADDR_W-1:0] i_addr,
  output logic [IDATA_W-1:0] i_rdata,
  output logic               i_ack,
  output logic               i_err,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [DADDR_W-1:0] d_addr,
  input  logic [DDATA_W-1:0] d_wdata,
  output logic [DDATA_W-1:0] d_rdata,
  output logic               d_ack,
  output logic               d_err,
  output logic               bus_req,
  output logic               bus_space,
  output logic               bus_we,
  output logic [IADDR_W-1:0] bus_addr,
  output logic [DDATA_W-1:0] bus_wdata,
  input  logic [IDATA_W-1:0] bus_rdata,
  input  logic               bus_ack
);

  arb_state_t         state_q, state_d;
  logic               last_q, last_d;
  logic               bus_req_q, bus_req_d;
  logic               bus_space_q, bus_space_d;
  logic               bus_we_q, bus_we_d;
  logic [IADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DDATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [IDATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DDATA_W-1:0] d_rdata_q, d_rdata_d;
  logic               i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic               d_ack_q, d_ack_d, d_err_q, d_err_d;

  // Ack capture that runs even with clk_en low, so a bus_ack pulse during a
  // disabled cycle (and its read data) is not lost.
  logic               ack_seen_q;
  logic [IDATA_W-1:0] ack_data_q;

  logic               grant;
  logic               wd_en;
  logic               wd_expired;
  logic               any_ack;
  logic               timed_out;
  logic               pick_inst;
  logic [IDATA_W-1:0] rdata_sel;

  assign grant   = clk_en && (state_q == IDLE) && (i_req || d_req);
  assign wd_en   = clk_en && (state_q == BUSY);
  assign any_ack = ack_seen_q || bus_ack;

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .sync_rst  (sync_rst),
    .clr_i     (grant),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  // NOTE: every signal assigned here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    bus_req_d   = bus_req_q;
    bus_space_d = bus_space_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    i_err_d     = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    pick_inst   = 1'b0;
    timed_out   = 1'b0;
    rdata_sel   = '0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // On a tie the side not served last wins.
          pick_inst = i_req && (!d_req || (last_q == SPACE_DATA));
          bus_req_d = 1'b1;
          state_d   = BUSY;
          if (pick_inst) begin
            bus_space_d = SPACE_INST;
            bus_we_d    = 1'b0;
            bus_addr_d  = i_addr;
            bus_wdata_d = '0;
          end else begin
            bus_space_d = SPACE_DATA;
            bus_we_d    = d_we;
            bus_addr_d  = {{(IADDR_W-DADDR_W){1'b0}}, d_addr};
            bus_wdata_d = d_wdata;
          end
        end
      end

      BUSY: begin
        if (any_ack || wd_expired) begin
          // A real ack wins over a watchdog expiry in the same cycle.
          timed_out = !any_ack;
          if (timed_out) begin
            rdata_sel = '0;
          end else if (bus_ack) begin
            rdata_sel = bus_rdata;
          end else begin
            rdata_sel = ack_data_q;
          end
          if (bus_space_q == SPACE_INST) begin
            i_rdata_d = rdata_sel;
            i_ack_d   = 1'b1;
            i_err_d   = timed_out;
          end else begin
            d_rdata_d = rdata_sel[DDATA_W-1:0];
            d_ack_d   = 1'b1;
            d_err_d   = timed_out;
          end
          bus_req_d = 1'b0;
          last_d    = bus_space_q;
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: reset is checked ahead of clk_en so it takes effect even while the
  // clock enable is low; every output register, data included, is reset.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q     <= IDLE;
      last_q      <= SPACE_DATA;
      bus_req_q   <= 1'b0;
      bus_space_q <= SPACE_INST;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      last_q      <= last_d;
      bus_req_q   <= bus_req_d;
      bus_space_q <= bus_space_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      i_err_q     <= i_err_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
    end
  end

  // Only acks inside BUSY count; the flag restarts with every grant.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      ack_seen_q <= 1'b0;
      ack_data_q <= '0;
    end else if (grant) begin
      ack_seen_q <= 1'b0;
    end else if ((state_q == BUSY) && bus_ack && !ack_seen_q) begin
      ack_seen_q <= 1'b1;
      ack_data_q <= bus_rdata;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_space = bus_space_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer that shares one external single-port memory bus between the instruction-cache refill path (16-bit, read-only, 10-bit word address) and the core data path (8-bit read/write, 8-bit address). It sits at the CPU top level between the icache/core memory ports and the board memory controller. It grants round-robin, runs exactly one bus transaction at a time, and returns a one-cycle acknowledge with registered read data. A watchdog terminates hung transactions.

## Interface
- `TIMEOUT`, 255: bus cycles without `bus_ack` before forced completion; range 1..255.
- `clk` in 1: clock.
- `clk_en` in 1: global clock enable; FSM, watchdog and round-robin state update only when high.
- `sync_rst` in 1: reset, synchronous and active-high.
- `i_req` in 1: instruction read request, held until `i_ack`.
- `i_addr` in 10: instruction word address.
- `i_rdata` out 16: instruction read data, valid with `i_ack`.
- `i_ack` out 1: one-cycle completion pulse, instruction side.
- `i_err` out 1: pulses with `i_ack` on a watchdog completion.
- `d_req` in 1: data request, held until `d_ack`.
- `d_we` in 1: data write enable, qualified by `d_req`.
- `d_addr` in 8: data byte address.
- `d_wdata` in 8: data write value.
- `d_rdata` out 8: data read value, `bus_rdata[7:0]`, valid with `d_ack`.
- `d_ack` out 1: one-cycle completion pulse, data side.
- `d_err` out 1: pulses with `d_ack` on a watchdog completion.
- `bus_req` out 1: external transaction active.
- `bus_space` out 1: 0 = instruction space, 1 = data space.
- `bus_we` out 1: write; always 0 when `bus_space` = 0.
- `bus_addr` out 10: address; data addresses are zero-extended.
- `bus_wdata` out 8: write data.
- `bus_rdata` in 16: read data, sampled in the `bus_ack` cycle.
- `bus_ack` in 1: memory completion pulse.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Samples `i_req`/`d_req`.
  - If exactly one is high, that requester is granted.
  - If both are high, the requester not served last is granted (round-robin). `last_served` resets to DATA, so after reset the instruction side wins the first tie.
  - On a grant, the requester's address, write data and we are latched into bus output registers, `bus_req` is set, and the FSM moves to BUSY.
- BUSY:
  - Bus outputs are held stable.
  - `ack_seen` is a flag set by `bus_ack` on any clock, independent of `clk_en`. It is cleared on entry to BUSY.
  - When `ack_seen` (or `bus_ack`) is high and `clk_en` is high:
    - `bus_rdata` is captured into the granted side's rdata register.
    - `bus_req` is cleared.
    - `last_served` is updated.
    - The FSM moves to DONE.
  - Watchdog: an 8-bit counter, cleared on the grant, increments each enabled cycle in BUSY. On reaching `TIMEOUT`, the FSM behaves as an ack with rdata forced to 0 and the err flag set.
- DONE:
  - The granted side's ack is high for exactly one cycle, plus err if the watchdog completed the transaction.
  - No arbitration happens in DONE.
  - Next state is IDLE.
  - A requester still holding req in IDLE is treated as a new request.
- `i_rdata`/`d_rdata` hold their last captured value until the next completion on that side.
- `bus_ack` arriving outside BUSY is ignored. `ack_seen` is not set.
- Reset at any point:
  - State becomes IDLE.
  - `bus_req`, `bus_we`, `bus_space`, both acks and both errs go to 0.
  - `bus_addr`, `bus_wdata`, `i_rdata`, `d_rdata` and the watchdog go to 0.
  - `last_served` goes to DATA.
  - An in-flight transaction is abandoned with no ack.

## Timing
- All outputs are registered.
- Request seen in IDLE at cycle N: `bus_req` is high from N+1.
- `bus_ack` at cycle M with `clk_en` high: `bus_req` is low and `x_ack` high at M+1; IDLE at M+2.
- Minimum transaction occupancy (`bus_ack` in the first BUSY cycle) is 3 cycles; back-to-back grants are 3 cycles apart.
- With `clk_en` low, all registered state holds except `ack_seen`. Completion occurs in the first enabled cycle after the ack.
- Watchdog completion: `x_ack`/`x_err` at grant + `TIMEOUT` + 1 enabled cycles.

## Structure
- Shared package `batpu_pkg`:
  - `arb_state_t` enum {IDLE, BUSY, DONE}.
  - `SPACE_INST` = 1'b0, `SPACE_DATA` = 1'b1.
  - Width constants `IADDR_W` = 10, `DADDR_W` = 8, `IDATA_W` = 16, `DDATA_W` = 8.
- One sub-module, `mem_watchdog`:
  - Enable-gated counter with clear and `expired` output, parameterised by `TIMEOUT`.
- Everything else stays in the top module.

## Test plan
- Lone `i_req`, `i_addr`=0x155, `bus_ack` on the first BUSY cycle with `bus_rdata`=0xBEEF:
  - `bus_space`=0, `bus_addr`=0x155 from N+1.
  - `i_ack`=1 and `i_rdata`=0xBEEF exactly one cycle.
  - `d_ack` stays 0.
- Lone `d_req` write, `d_addr`=0x42, `d_wdata`=0x7E, ack after 4 cycles:
  - `bus_we`=1, `bus_space`=1, `bus_addr`=0x042, `bus_wdata`=0x7E, all stable until the ack.
  - `d_ack` one cycle.
- `i_req` and `d_req` held high continuously:
  - Grants alternate I, D, I, D starting with I after reset.
  - Each grant is 3 cycles apart with immediate acks.
- `bus_ack` pulsed while `clk_en`=0 during BUSY, `bus_rdata`=0x00A5:
  - Completion is delayed to the first cycle with `clk_en`=1.
  - `d_rdata`=0xA5.
- `TIMEOUT`=4, no `bus_ack`:
  - `i_ack`=1, `i_err`=1, `i_rdata`=0 at grant + 5.
  - `bus_req` low.
  - Next request arbitrates normally.
- `sync_rst` asserted mid-BUSY:
  - The next cycle has all outputs at reset values, no ack, state IDLE.
  - A tie afterwards grants the instruction side.
